// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester write-port arbiter with holding buffers
// Round-robin with age override for same-address pairs, registered WE3/A3/WD3 stage.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              grant_id,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic              rd_stall
);

  logic              full0_q, full0_d, full1_q, full1_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              prio_q, prio_d, old_q, old_d;
  logic              we3_q, we3_d, gid_q, gid_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              grant0, grant1, winner, xfer0, xfer1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    winner = 1'b0;
    if (full0_q && full1_q) begin
      winner = (addr0_q == addr1_q) ? old_q : prio_q;
      grant0 = ~winner;
      grant1 = winner;
    end else begin
      grant0 = full0_q;
      grant1 = full1_q;
    end
  end

  assign req0_ready = ~RST & (~full0_q | grant0);
  assign req1_ready = ~RST & (~full1_q | grant1);
  assign xfer0      = req0_valid & req0_ready;
  assign xfer1      = req1_valid & req1_ready;

  always_comb begin
    full0_d = xfer0 | (full0_q & ~grant0);
    full1_d = xfer1 | (full1_q & ~grant1);
    addr0_d = xfer0 ? req0_addr : addr0_q;
    data0_d = xfer0 ? req0_data : data0_q;
    addr1_d = xfer1 ? req1_addr : addr1_q;
    data1_d = xfer1 ? req1_data : data1_q;
    prio_d  = (grant0 | grant1) ? grant0 : prio_q;
    // Entries loaded together have no age order; copying the next prio makes old defer to it.
    if (xfer0 && xfer1)
      old_d = prio_d;
    else if (xfer0 && full1_q && !grant1)
      old_d = 1'b1;
    else if (xfer1 && full0_q && !grant0)
      old_d = 1'b0;
    else
      old_d = old_q;
    we3_d = grant0 | grant1;
    a3_d  = grant0 ? addr0_q : (grant1 ? addr1_q : a3_q);
    wd3_d = grant0 ? data0_q : (grant1 ? data1_q : wd3_q);
    gid_d = grant1 ? 1'b1 : (grant0 ? 1'b0 : gid_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      addr0_q <= '0;
      data0_q <= '0;
      addr1_q <= '0;
      data1_q <= '0;
      prio_q  <= 1'b0;
      old_q   <= 1'b0;
      we3_q   <= 1'b0;
      a3_q    <= '0;
      wd3_q   <= '0;
      gid_q   <= 1'b0;
    end else begin
      full0_q <= full0_d;
      full1_q <= full1_d;
      addr0_q <= addr0_d;
      data0_q <= data0_d;
      addr1_q <= addr1_d;
      data1_q <= data1_d;
      prio_q  <= prio_d;
      old_q   <= old_d;
      we3_q   <= we3_d;
      a3_q    <= a3_d;
      wd3_q   <= wd3_d;
      gid_q   <= gid_d;
    end
  end

  assign WE3      = we3_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign grant_id = gid_q;

  assign rd_stall = (full0_q & (A1 == addr0_q)) | (full1_q & (A1 == addr1_q)) | (we3_q & (A1 == a3_q)) |
                    (full0_q & (A2 == addr0_q)) | (full1_q & (A2 == addr1_q)) | (we3_q & (A2 == a3_q));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr, A1, A2, A3;
  logic [DW-1:0] req0_data, req1_data, WD3;
  logic          WE3, grant_id, rd_stall;

  int checks = 0;
  int failures = 0;

  logic          mon_en = 1'b0;
  logic [DW-1:0] commits5 [$];

  always #5 CLK = ~CLK;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .WE3(WE3), .A3(A3), .WD3(WD3), .grant_id(grant_id),
    .A1(A1), .A2(A2), .rd_stall(rd_stall)
  );

  always @(negedge CLK)
    if (mon_en && WE3 === 1'b1 && A3 === AW'(5)) commits5.push_back(WD3);

  task automatic do_reset();
    RST = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    req0_valid = 1'b1; req0_addr = AW'(3); req0_data = 32'hDEAD;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    A1 = '0; A2 = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
    checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL reset_we3 got=%b exp=0", WE3); end
    checks++; if (A3 !== '0) begin failures++; $display("FAIL reset_a3 got=%0d exp=0", A3); end
    checks++; if (WD3 !== '0) begin failures++; $display("FAIL reset_wd3 got=%h exp=0", WD3); end
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL reset_gid got=%b exp=0", grant_id); end
    checks++; if (rd_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", rd_stall); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    req0_valid = 1'b0;
  endtask

  task automatic test_single_write();
    req0_valid = 1'b1; req0_addr = AW'(3); req0_data = 32'h2A;
    A1 = AW'(3); A2 = '0;
    @(negedge CLK);
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", req0_ready); end
    @(posedge CLK);
    #1;
    req0_valid = 1'b0;
    @(negedge CLK);
    checks++; if (rd_stall !== 1'b1) begin failures++; $display("FAIL single_stall_t1 got=%b exp=1", rd_stall); end
    checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL single_we3_t1 got=%b exp=0", WE3); end
    @(negedge CLK);
    checks++; if (WE3 !== 1'b1) begin failures++; $display("FAIL single_we3_t2 got=%b exp=1", WE3); end
    checks++; if (A3 !== AW'(3)) begin failures++; $display("FAIL single_a3 got=%0d exp=3", A3); end
    checks++; if (WD3 !== 32'h2A) begin failures++; $display("FAIL single_wd3 got=%h exp=2a", WD3); end
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL single_gid got=%b exp=0", grant_id); end
    checks++; if (rd_stall !== 1'b1) begin failures++; $display("FAIL single_stall_t2 got=%b exp=1", rd_stall); end
    @(negedge CLK);
    checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL single_we3_t3 got=%b exp=0", WE3); end
    checks++; if (rd_stall !== 1'b0) begin failures++; $display("FAIL single_stall_t3 got=%b exp=0", rd_stall); end
    checks++; if (A3 !== AW'(3)) begin failures++; $display("FAIL single_a3_hold got=%0d exp=3", A3); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_round_robin();
    logic exp_g;
    do_reset();
    req0_valid = 1'b1; req0_addr = AW'(1); req0_data = 32'h100;
    req1_valid = 1'b1; req1_addr = AW'(2); req1_data = 32'h200;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rr_first_ready0 got=%b exp=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL rr_first_ready1 got=%b exp=0", req1_ready); end
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      exp_g = k[0];
      checks++; if (WE3 !== 1'b1) begin failures++; $display("FAIL rr_we3 k=%0d got=%b exp=1", k, WE3); end
      checks++; if (grant_id !== exp_g) begin failures++; $display("FAIL rr_gid k=%0d got=%b exp=%b", k, grant_id, exp_g); end
      checks++; if (A3 !== (exp_g ? AW'(2) : AW'(1))) begin failures++; $display("FAIL rr_a3 k=%0d got=%0d", k, A3); end
      checks++; if (req0_ready !== exp_g) begin failures++; $display("FAIL rr_ready0 k=%0d got=%b exp=%b", k, req0_ready, exp_g); end
      checks++; if (req1_ready !== !exp_g) begin failures++; $display("FAIL rr_ready1 k=%0d got=%b exp=%b", k, req1_ready, !exp_g); end
    end
    @(posedge CLK);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic send(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic done;
    done = 1'b0;
    if (idx == 0) begin req0_valid = 1'b1; req0_addr = a; req0_data = d; end
    else begin req1_valid = 1'b1; req1_addr = a; req1_data = d; end
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge CLK);
      if ((idx == 0) ? req0_ready : req1_ready) done = 1'b1;
      @(posedge CLK);
      #1;
    end
    if (idx == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL send_timeout req=%0d addr=%0d got=0 exp=1", idx, a); end
  endtask

  task automatic test_same_addr_order();
    do_reset();
    commits5.delete();
    mon_en = 1'b1;
    fork
      begin
        send(0, AW'(7), 32'hA0);
        send(0, AW'(7), 32'hA1);
        send(0, AW'(5), 32'h22);
      end
      begin
        send(1, AW'(9), 32'hB0);
        send(1, AW'(5), 32'h11);
      end
    join
    repeat (6) @(posedge CLK);
    #1;
    mon_en = 1'b0;
    checks++; if (commits5.size() != 2) begin failures++; $display("FAIL order_count got=%0d exp=2", commits5.size()); end
    if (commits5.size() == 2) begin
      checks++; if (commits5[0] !== 32'h11) begin failures++; $display("FAIL order_first got=%h exp=11", commits5[0]); end
      checks++; if (commits5[1] !== 32'h22) begin failures++; $display("FAIL order_second got=%h exp=22", commits5[1]); end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req0_valid = 1'b1; req0_addr = AW'(1); req0_data = 32'h111;
    req1_valid = 1'b1; req1_addr = AW'(2); req1_data = 32'h222;
    A1 = AW'(1); A2 = AW'(2);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge CLK);
    checks++; if (WE3 !== 1'b1 || grant_id !== 1'b0) begin failures++; $display("FAIL mid_pre got=%b/%b exp=1/0", WE3, grant_id); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b%b exp=00", req0_ready, req1_ready); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL mid_we3 k=%0d got=%b exp=0", k, WE3); end
      checks++; if (rd_stall !== 1'b0) begin failures++; $display("FAIL mid_stall k=%0d got=%b exp=0", k, rd_stall); end
    end
    @(posedge CLK);
    #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(posedge CLK);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (WE3 !== 1'b1 || grant_id !== 1'b0 || A3 !== AW'(1)) begin failures++; $display("FAIL mid_prio0 got=%b/%b/%0d exp=1/0/1", WE3, grant_id, A3); end
    @(negedge CLK);
    checks++; if (WE3 !== 1'b1 || grant_id !== 1'b1 || WD3 !== 32'h222) begin failures++; $display("FAIL mid_second got=%b/%b/%h exp=1/1/222", WE3, grant_id, WD3); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_random();
    logic          m_full [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    int            m_stamp [2];
    logic          m_prio, m_we, m_gid, stall;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd3;
    logic          rdy [2];
    logic          vld [2];
    logic [AW-1:0] in_a [2];
    logic [DW-1:0] in_d [2];
    logic [AW-1:0] rd [2];
    int            g;
    do_reset();
    for (int i = 0; i < 2; i++) begin m_full[i] = 0; m_addr[i] = '0; m_data[i] = '0; m_stamp[i] = 0; end
    m_prio = 0; m_we = 0; m_gid = 0; m_a3 = '0; m_wd3 = '0;
    for (int n = 0; n < 600; n++) begin
      RST = ($urandom_range(0, 63) == 0);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_addr = AW'($urandom_range(0, 3));
      req1_addr = AW'($urandom_range(0, 3));
      req0_data = $urandom;
      req1_data = $urandom;
      A1 = AW'($urandom_range(0, 4));
      A2 = AW'($urandom_range(0, 4));
      vld[0] = req0_valid; vld[1] = req1_valid;
      in_a[0] = req0_addr; in_a[1] = req1_addr;
      in_d[0] = req0_data; in_d[1] = req1_data;
      rd[0] = A1; rd[1] = A2;
      g = -1;
      if (m_full[0] && m_full[1]) begin
        if (m_addr[0] == m_addr[1] && m_stamp[0] != m_stamp[1]) g = (m_stamp[0] < m_stamp[1]) ? 0 : 1;
        else g = int'(m_prio);
      end else if (m_full[0]) g = 0;
      else if (m_full[1]) g = 1;
      for (int i = 0; i < 2; i++) rdy[i] = !RST && (!m_full[i] || g == i);
      stall = 0;
      for (int r = 0; r < 2; r++)
        for (int i = 0; i < 2; i++)
          if ((m_full[i] && rd[r] == m_addr[i]) || (m_we && rd[r] == m_a3)) stall = 1;
      @(negedge CLK);
      checks++; if (req0_ready !== rdy[0]) begin failures++; $display("FAIL rand_ready0 n=%0d got=%b exp=%b", n, req0_ready, rdy[0]); end
      checks++; if (req1_ready !== rdy[1]) begin failures++; $display("FAIL rand_ready1 n=%0d got=%b exp=%b", n, req1_ready, rdy[1]); end
      checks++; if (rd_stall !== stall) begin failures++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, rd_stall, stall); end
      checks++; if (WE3 !== m_we || A3 !== m_a3 || WD3 !== m_wd3 || grant_id !== m_gid)
        begin failures++; $display("FAIL rand_out n=%0d got=%b/%0d/%h/%b exp=%b/%0d/%h/%b", n, WE3, A3, WD3, grant_id, m_we, m_a3, m_wd3, m_gid); end
      @(posedge CLK);
      if (RST) begin
        for (int i = 0; i < 2; i++) m_full[i] = 0;
        m_prio = 0; m_we = 0; m_gid = 0; m_a3 = '0; m_wd3 = '0;
      end else begin
        m_we = (g >= 0);
        if (g >= 0) begin
          m_a3 = m_addr[g]; m_wd3 = m_data[g]; m_gid = (g == 1);
          m_prio = (g == 0); m_full[g] = 0;
        end
        for (int i = 0; i < 2; i++)
          if (vld[i] && rdy[i]) begin m_full[i] = 1; m_addr[i] = in_a[i]; m_data[i] = in_d[i]; m_stamp[i] = n; end
      end
      #1;
    end
    RST = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_same_addr_order();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
